// File: rtl/ps2_key_port_if.sv
// ps2_key_port_if: groups the raw PS/2 pins and the core-side keyboard port.
// master = device pins plus core ack (stimulus side), slave = ps2_key_port.
// keyboard_in carries status/data; keyboard_ack pops one entry per cycle held.
interface ps2_key_port_if;
    logic        ps2_clock;
    logic        ps2_data;
    logic        keyboard_ack;
    logic [31:0] keyboard_in;

    modport master (
        output ps2_clock,
        output ps2_data,
        output keyboard_ack,
        input  keyboard_in
    );

    modport slave (
        input  ps2_clock,
        input  ps2_data,
        input  keyboard_ack,
        output keyboard_in
    );
endinterface

// File: rtl/ps2_key_port.sv
// ps2_key_port: PS/2 frame receiver feeding a scancode FIFO read by the core's input port.
// Latency: raw falling edge seen 3 clocks later; byte visible 1 clock after stop edge; pop 1 clock.
// Backpressure: none toward the device; a full FIFO drops the byte and sets sticky overflow.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames failing odd parity are discarded.
module ps2_key_port #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 5000
) (
    input  logic          clock,
    input  logic          reset,
    ps2_key_port_if.slave kbd
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Synchronizers and edge register; idle-high so reset never fakes an edge.
    logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic ps2d_s1_q, ps2d_s2_q;
    logic fall;

    // Two-flop synchronizers plus a delayed copy of the synced clock for edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= kbd.ps2_clock;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= kbd.ps2_data;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    assign fall = ps2c_prev_q & ~ps2c_s2_q;

    // Frame receiver state
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          accept;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    // Receiver register bank
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state: advance one frame bit per PS/2 falling edge, abandon a stalled frame.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        accept    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif
        // Gap counter saturates at TIMEOUT; a real edge always restarts it.
        if (state_q == S_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fall && !ps2d_s2_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = ps2d_s2_q;
`endif
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    accept = ps2d_s2_q & (^{shift_q, parity_q});
`else
                    accept = ps2d_s2_q;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !fall && tmo_q == TMO_MAX) begin
            state_d = S_IDLE;
        end
    end

    // Scancode FIFO
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;
    logic          empty, full, pop, push, drop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign pop   = kbd.keyboard_ack & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO can still take the byte.
    assign push  = accept & (~full | pop);
    assign drop  = accept & full & ~pop;

    // Storage is not reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers, occupancy and sticky overflow; a drop wins over an ack clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (kbd.keyboard_ack) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign kbd.keyboard_in = {~empty, ovf_q, 22'd0, empty ? 8'h00 : mem[rd_ptr_q]};

endmodule
